// File: rtl/move_input.sv
// Push-button front end for the puzzle game: synchronizes, debounces, auto-repeats
// directions and arbitrates six buttons into single-cycle registered command pulses.
module move_input #(
   parameter int DEBOUNCE      = 1000000,
   parameter int REPEAT_DELAY  = 25000000,
   parameter int REPEAT_PERIOD = 10000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_up,
   input  logic btn_down,
   input  logic btn_left,
   input  logic btn_right,
   input  logic btn_retract,
   input  logic btn_retry,
   input  logic hold,
   output logic up,
   output logic down,
   output logic left,
   output logic right,
   output logic retract,
   output logic retry
);

   localparam int DW   = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = (RMAX > 2) ? $clog2(RMAX) : 1;

   localparam logic [1:0] R_IDLE   = 2'd0;
   localparam logic [1:0] R_DELAY  = 2'd1;
   localparam logic [1:0] R_PERIOD = 2'd2;

   // Key index: 0 up, 1 down, 2 left, 3 right, 4 retract, 5 retry
   logic [5:0]    raw;
   logic [5:0]    sync1;
   logic [5:0]    sync2;
   logic [5:0]    deb;
   logic [5:0]    deb_d;
   logic [5:0]    armed;
   logic [5:0]    press_req;
   logic [5:0]    rpt_req;
   logic [5:0]    req;
   logic [5:0]    grant;
   logic [5:0]    pulse;
   logic [DW-1:0] dcnt [6];
   logic [RW-1:0] rcnt;
   logic [1:0]    rstate;
   logic [3:0]    dir_held;
   logic          single;
   logic          rpt_hit;

   assign raw = {btn_retry, btn_retract, btn_right, btn_left, btn_down, btn_up};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Level flips only after DEBOUNCE consecutive mismatching cycles; any match restarts the count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         deb   <= '0;
         deb_d <= '0;
         armed <= '1;
         for (int i = 0; i < 6; i++) dcnt[i] <= '0;
      end else begin
         deb_d <= deb;
         for (int i = 0; i < 6; i++) begin
            if (sync2[i] == deb[i]) begin
               dcnt[i] <= '0;
            end else if (dcnt[i] == DW'(DEBOUNCE - 1)) begin
               deb[i]  <= ~deb[i];
               dcnt[i] <= '0;
            end else begin
               dcnt[i] <= dcnt[i] + 1'b1;
            end
            if (!deb[i])
               armed[i] <= 1'b1;
            else if (hold)
               armed[i] <= 1'b0;
         end
      end
   end

   assign dir_held  = deb[3:0];
   assign single    = !hold && (dir_held != 4'd0) && ((dir_held & (dir_held - 4'd1)) == 4'd0)
                      && ((dir_held & armed[3:0]) != 4'd0);
   assign rpt_hit   = single && (((rstate == R_DELAY)  && (rcnt == RW'(REPEAT_DELAY - 1))) ||
                                 ((rstate == R_PERIOD) && (rcnt == RW'(REPEAT_PERIOD - 1))));
   assign press_req = deb & ~deb_d & armed;
   assign rpt_req   = rpt_hit ? {2'b00, dir_held} : 6'b0;
   assign req       = hold ? 6'b0 : (press_req | rpt_req);

   always_comb begin
      grant = '0;
      if (req[5])      grant[5] = 1'b1;
      else if (req[4]) grant[4] = 1'b1;
      else if (req[0]) grant[0] = 1'b1;
      else if (req[1]) grant[1] = 1'b1;
      else if (req[2]) grant[2] = 1'b1;
      else if (req[3]) grant[3] = 1'b1;
   end

   // Repeat timing only starts from a direction press that actually won arbitration
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rstate <= R_IDLE;
         rcnt   <= '0;
      end else if (!single) begin
         rstate <= R_IDLE;
         rcnt   <= '0;
      end else if ((grant[3:0] & press_req[3:0]) != 4'd0) begin
         rstate <= R_DELAY;
         rcnt   <= '0;
      end else if (rpt_hit) begin
         rstate <= R_PERIOD;
         rcnt   <= '0;
      end else if (rstate != R_IDLE) begin
         rcnt <= rcnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pulse <= '0;
      else     pulse <= grant;
   end

   assign up      = pulse[0];
   assign down    = pulse[1];
   assign left    = pulse[2];
   assign right   = pulse[3];
   assign retract = pulse[4];
   assign retry   = pulse[5];

endmodule
